axi_cpl_info_arbiter: RTL and testbench
=======================================

// Module: axi_cpl_info_arbiter
// PURPOSE
//  Registered, round-robin successor of the R/B completion-info mapper in the master bridge.
//  Pops response info from the AXI R-info and B-info FIFOs and arbitrates fairly when both are non-empty.
//  Maps each popped entry to completion-generator fields (incl. lower address, initial byte count) and
//  holds them in a one-entry output register with a valid/accept handshake.
// PARAMETERS
//  ID_WIDTH            10  AXI RID/BID width; zero-extended or truncated to TAG_WIDTH
//  TAG_WIDTH           10  completion tag width
//  REQUESTER_ID_WIDTH  16  requester ID width
//  LEN_FIELD_WIDTH     10  DW length field; 0 encodes 1024 DW
//  TC_WIDTH            3   traffic class width
//  LOWER_ADDR_FIELD    7   lower address width = ADDR_LSBS_PORTION + 2
//  BYTE_ENABLES_WIDTH  4   first/last DW byte-enable width
//  ADDR_LSBS_PORTION   5   request address bits [6:2] carried in RUSER
//  BYTE_COUNT_WIDTH    12  byte count width; 4096 encodes as 0
//  RESP_WIDTH          2   AXI xRESP width
//  R_USER_SIG_WIDTH    43  {req_id, first_be, last_be, addr_lsbs, tc, length, mem_not_io}
//  B_USER_SIG_WIDTH    19  {req_id, tc}
// PORTS
//  i_clk                      in   1     clock
//  i_n_rst                    in   1     asynchronous reset, active low
//  i_BID/i_BRESP/i_BUSER      in   ID/RESP/B_USER  head of B-info FIFO
//  i_BVALID_fifo              in   1     B FIFO non-empty
//  o_b_ch_read_inc            out  1     pop B FIFO (1-cycle pulse)
//  i_RID/i_RRESP/i_RUSER      in   ID/RESP/R_USER  head of R-info FIFO
//  i_RVALID_fifo              in   1     R FIFO non-empty
//  o_r_ch_read_info_inc       out  1     pop R FIFO (1-cycle pulse)
//  i_cpl_info_inc             in   1     completion generator accepts held entry
//  o_requester_id/o_cpl_tag/o_cpl_traffic_class/o_cpl_length/o_cpl_lower_address/
//  o_cpl_initial_byte_count   out  per param  registered completion fields
//  o_cpl_type                 out  1     1 = CplD (memory read), 0 = Cpl
//  o_cpl_error_flag           out  1     xRESP is SLVERR or DECERR
//  o_cpl_status               out  3     only with AXI_CPL_STATUS_EN
//  o_cpl_valid                out  1     output register holds a valid entry
// BEHAVIOUR
//  - Reset: all outputs 0, o_cpl_valid=0, holding state EMPTY, rr priority = READ.
//  - States: EMPTY, FULL. load_en = EMPTY | (FULL & i_cpl_info_inc).
//  - On load_en: if exactly one FIFO is valid, grant it. If both are valid, grant the rr-priority channel,
//    then flip priority to the other. Priority does not change when only one requester is present.
//    Pulse that channel's pop in the same cycle, register the mapped fields, set o_cpl_valid.
//  - load_en with no FIFO valid: FULL->EMPTY and o_cpl_valid drops. A pop is never issued without a load.
//  - Latency: FIFO valid to o_cpl_valid = 1 cycle. Back-to-back accepts give 1 entry/cycle (no bubble).
//  - i_cpl_info_inc while EMPTY is ignored. Fields stay stable while FULL and not accepted.
//  - R mapping: tag=RID; type=DATA iff mem_not_io. Lower address = {addr_lsbs, be_off} for memory reads,
//    0 for IO. be_off is the index of the lowest set first_be bit (0 if none).
//  - R initial byte count, memory read: length==1 and last_be==0 -> span from lowest to highest set
//    first_be bit (1 if first_be==0). Otherwise len*4 - lead(first_be) - trail(last_be), computed
//    modulo 2^BYTE_COUNT_WIDTH. IO read: 4.
//  - B mapping: tag=BID, length=1, lower address=0, type=NODATA, byte count=4.
//  - error_flag = (resp==SLVERR)|(resp==DECERR). EXOKAY counts as success.
//  - Reset asserted mid-operation discards the held entry. Any pop already pulsed is not undone.
// CONFIGURATION
//  AXI_CPL_STATUS_EN defined: o_cpl_status is registered with the entry.
//    OKAY/EXOKAY -> 3'b000 (SC), SLVERR -> 3'b100 (CA), DECERR -> 3'b001 (UR).
//  AXI_CPL_STATUS_EN undefined: port absent. Only o_cpl_error_flag is provided; downstream assumes UR.
// STRUCTURE
//  - Shared include axi_pcie_cpl_defs.vh holds: RESP codes, READ_RESP/WRITE_RESP, IO/MEMORY,
//    NODATA/DATA, CPL status codes, and the RUSER/BUSER field offsets.
//  - Sub-module cpl_byte_count_calc: combinational; first_be, last_be, length, mem_not_io -> byte count
//    and be_off. Reused by the split-completion path.
// TESTING
//  1. Only R valid: RUSER first_be=4'b1111, last_be=4'b1111, len=4, mem, RID=5 -> 1 cycle later
//     valid, tag=5, type=1, byte count=16, lower address[1:0]=0; one pop pulse.
//  2. Both FIFOs valid continuously, i_cpl_info_inc=1 -> grants alternate R,B,R,B; 1 entry/cycle.
//  3. B valid, BRESP=DECERR, BUSER tc=3 -> error=1, length=1, byte count=4, lower address=0.
//     With AXI_CPL_STATUS_EN: status=3'b001.
//  4. len=1, first_be=4'b0110, last_be=0, addr_lsbs=5'h3 -> byte count=2, lower address=7'h0D.
//  5. len=0 (1024 DW), both BEs=4'hF -> byte count=0 (4096). First_be=4'b1000, last_be=4'b0001,
//     len=3 -> byte count=6.
//  6. FULL, i_cpl_info_inc held 0 for 5 cycles with both FIFOs valid -> no pops, outputs stable.
//     Then assert i_n_rst low -> o_cpl_valid=0 asynchronously.

Source files
------------

// File: rtl/axi_cpl_info_arbiter_pkg.sv
// Shared definitions for the AXI R/B completion-info arbiter: AXI response
// codes, round-robin priority encoding, address-space and completion-type
// encodings, completion status codes and the holding-register state type.
package axi_cpl_info_arbiter_pkg;

    // AXI xRESP encodings
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Round-robin priority: which response channel wins the next tie
    typedef enum logic {
        READ_RESP  = 1'b0,
        WRITE_RESP = 1'b1
    } rr_prio_e;

    // RUSER mem_not_io bit: 1 = memory read, 0 = IO read
    localparam logic MEMORY = 1'b1;

    // Completion type: CplD carries data, Cpl does not
    localparam logic NODATA = 1'b0;
    localparam logic DATA   = 1'b1;

    // Completion status codes
    localparam logic [2:0] CPL_STATUS_SC = 3'b000;
    localparam logic [2:0] CPL_STATUS_UR = 3'b001;
    localparam logic [2:0] CPL_STATUS_CA = 3'b100;

    // One-entry output holding register
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } hold_state_e;

    // EXOKAY is a successful response; only SLVERR and DECERR are errors
    function automatic logic resp_is_error(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

    // Map an AXI response onto a completion status
    function automatic logic [2:0] resp_to_status(input logic [1:0] resp);
        logic [2:0] status;
        case (resp)
            RESP_OKAY,
            RESP_EXOKAY: status = CPL_STATUS_SC;
            RESP_SLVERR: status = CPL_STATUS_CA;
            default:     status = CPL_STATUS_UR;
        endcase
        return status;
    endfunction

endpackage

// File: rtl/cpl_byte_count_calc.sv
// Combinational completion byte-count and lower-address offset calculator.
// Shared by the non-split completion-info path and the split-completion path.
// Byte count wraps modulo 2^BC_WIDTH, so a 1024-DW (length 0) full read
// produces 0, which is the encoding of 4096 bytes.
module cpl_byte_count_calc
    import axi_cpl_info_arbiter_pkg::*;
#(
    parameter int BE_WIDTH  = 4,
    parameter int LEN_WIDTH = 10,
    parameter int BC_WIDTH  = 12,
    parameter int OFF_WIDTH = 2
) (
    input  logic [BE_WIDTH-1:0]  first_be_i,
    input  logic [BE_WIDTH-1:0]  last_be_i,
    input  logic [LEN_WIDTH-1:0] length_i,
    input  logic                 mem_not_io_i,
    output logic [BC_WIDTH-1:0]  byte_count_o,
    output logic [OFF_WIDTH-1:0] be_off_o
);

    logic [OFF_WIDTH-1:0] fbe_lo;
    logic [OFF_WIDTH-1:0] fbe_hi;
    logic [OFF_WIDTH-1:0] lbe_hi;
    logic [BC_WIDTH-1:0]  lead_bytes;
    logic [BC_WIDTH-1:0]  trail_bytes;

    // Locate lowest/highest enabled byte lanes; an empty mask yields lane 0
    always_comb begin
        fbe_lo = '0;
        fbe_hi = '0;
        lbe_hi = '0;
        for (int i = BE_WIDTH - 1; i >= 0; i--) begin
            if (first_be_i[i]) fbe_lo = OFF_WIDTH'(i);
        end
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (first_be_i[i]) fbe_hi = OFF_WIDTH'(i);
            if (last_be_i[i])  lbe_hi = OFF_WIDTH'(i);
        end
    end

    // Disabled bytes before the first and after the last enabled byte
    always_comb begin
        lead_bytes  = BC_WIDTH'(fbe_lo);
        trail_bytes = '0;
        if (last_be_i != '0) begin
            trail_bytes = BC_WIDTH'(BE_WIDTH - 1) - BC_WIDTH'(lbe_hi);
        end
    end

    // Byte count: IO is always one DW; single-DW memory reads use the
    // first_be span; everything else is length*DW minus unused edge bytes
    always_comb begin
        byte_count_o = BC_WIDTH'(BE_WIDTH);
        if (mem_not_io_i == MEMORY) begin
            if ((length_i == LEN_WIDTH'(1)) && (last_be_i == '0)) begin
                if (first_be_i == '0) begin
                    byte_count_o = BC_WIDTH'(1);
                end else begin
                    byte_count_o = BC_WIDTH'(fbe_hi) - BC_WIDTH'(fbe_lo) + BC_WIDTH'(1);
                end
            end else begin
                byte_count_o = BC_WIDTH'(length_i) * BC_WIDTH'(BE_WIDTH)
                             - lead_bytes - trail_bytes;
            end
        end
    end

    assign be_off_o = fbe_lo;

endmodule

// File: rtl/axi_cpl_info_arbiter.sv
// Round-robin R/B completion-info arbiter with a one-entry registered output.
// Pops the AXI R-info or B-info FIFO head, maps it to completion-generator
// fields and holds them under a valid/accept handshake.
// Optional feature macro: AXI_CPL_STATUS_EN adds the registered o_cpl_status port.
module axi_cpl_info_arbiter
    import axi_cpl_info_arbiter_pkg::*;
#(
    parameter int ID_WIDTH           = 10,
    parameter int TAG_WIDTH          = 10,
    parameter int REQUESTER_ID_WIDTH = 16,
    parameter int LEN_FIELD_WIDTH    = 10,
    parameter int TC_WIDTH           = 3,
    parameter int LOWER_ADDR_FIELD   = 7,
    parameter int BYTE_ENABLES_WIDTH = 4,
    parameter int ADDR_LSBS_PORTION  = 5,
    parameter int BYTE_COUNT_WIDTH   = 12,
    parameter int RESP_WIDTH         = 2,
    parameter int R_USER_SIG_WIDTH   = 43,
    parameter int B_USER_SIG_WIDTH   = 19
) (
    input  logic                          i_clk,
    input  logic                          i_n_rst,
    input  logic [ID_WIDTH-1:0]           i_BID,
    input  logic [RESP_WIDTH-1:0]         i_BRESP,
    input  logic [B_USER_SIG_WIDTH-1:0]   i_BUSER,
    input  logic                          i_BVALID_fifo,
    output logic                          o_b_ch_read_inc,
    input  logic [ID_WIDTH-1:0]           i_RID,
    input  logic [RESP_WIDTH-1:0]         i_RRESP,
    input  logic [R_USER_SIG_WIDTH-1:0]   i_RUSER,
    input  logic                          i_RVALID_fifo,
    output logic                          o_r_ch_read_info_inc,
    input  logic                          i_cpl_info_inc,
    output logic [REQUESTER_ID_WIDTH-1:0] o_requester_id,
    output logic [TAG_WIDTH-1:0]          o_cpl_tag,
    output logic [TC_WIDTH-1:0]           o_cpl_traffic_class,
    output logic [LEN_FIELD_WIDTH-1:0]    o_cpl_length,
    output logic [LOWER_ADDR_FIELD-1:0]   o_cpl_lower_address,
    output logic [BYTE_COUNT_WIDTH-1:0]   o_cpl_initial_byte_count,
    output logic                          o_cpl_type,
    output logic                          o_cpl_error_flag,
`ifdef AXI_CPL_STATUS_EN
    output logic [2:0]                    o_cpl_status,
`endif
    output logic                          o_cpl_valid
);

    // RUSER layout, LSB first: mem_not_io, length, tc, addr_lsbs, last_be, first_be, req_id
    localparam int R_MEM_OFF  = 0;
    localparam int R_LEN_OFF  = R_MEM_OFF + 1;
    localparam int R_TC_OFF   = R_LEN_OFF + LEN_FIELD_WIDTH;
    localparam int R_ADDR_OFF = R_TC_OFF + TC_WIDTH;
    localparam int R_LBE_OFF  = R_ADDR_OFF + ADDR_LSBS_PORTION;
    localparam int R_FBE_OFF  = R_LBE_OFF + BYTE_ENABLES_WIDTH;
    localparam int R_RID_OFF  = R_FBE_OFF + BYTE_ENABLES_WIDTH;
    // BUSER layout, LSB first: tc, req_id
    localparam int B_TC_OFF   = 0;
    localparam int B_RID_OFF  = B_TC_OFF + TC_WIDTH;
    localparam int BE_OFF_W   = LOWER_ADDR_FIELD - ADDR_LSBS_PORTION;

    // R-info head fields
    logic                          r_mem_not_io;
    logic [LEN_FIELD_WIDTH-1:0]    r_length;
    logic [TC_WIDTH-1:0]           r_tc;
    logic [ADDR_LSBS_PORTION-1:0]  r_addr_lsbs;
    logic [BYTE_ENABLES_WIDTH-1:0] r_last_be;
    logic [BYTE_ENABLES_WIDTH-1:0] r_first_be;
    logic [REQUESTER_ID_WIDTH-1:0] r_req_id;
    logic [TAG_WIDTH-1:0]          r_tag;
    logic [BYTE_COUNT_WIDTH-1:0]   r_byte_count;
    logic [BE_OFF_W-1:0]           r_be_off;
    // B-info head fields
    logic [TC_WIDTH-1:0]           b_tc;
    logic [REQUESTER_ID_WIDTH-1:0] b_req_id;
    logic [TAG_WIDTH-1:0]          b_tag;

    assign r_mem_not_io = i_RUSER[R_MEM_OFF];
    assign r_length     = i_RUSER[R_LEN_OFF +: LEN_FIELD_WIDTH];
    assign r_tc         = i_RUSER[R_TC_OFF +: TC_WIDTH];
    assign r_addr_lsbs  = i_RUSER[R_ADDR_OFF +: ADDR_LSBS_PORTION];
    assign r_last_be    = i_RUSER[R_LBE_OFF +: BYTE_ENABLES_WIDTH];
    assign r_first_be   = i_RUSER[R_FBE_OFF +: BYTE_ENABLES_WIDTH];
    assign r_req_id     = i_RUSER[R_RID_OFF +: REQUESTER_ID_WIDTH];
    assign b_tc         = i_BUSER[B_TC_OFF +: TC_WIDTH];
    assign b_req_id     = i_BUSER[B_RID_OFF +: REQUESTER_ID_WIDTH];

    // AXI IDs become tags by truncation or zero extension
    generate
        if (ID_WIDTH >= TAG_WIDTH) begin : g_tag_trunc
            assign r_tag = i_RID[TAG_WIDTH-1:0];
            assign b_tag = i_BID[TAG_WIDTH-1:0];
        end else begin : g_tag_zext
            assign r_tag = {{(TAG_WIDTH - ID_WIDTH){1'b0}}, i_RID};
            assign b_tag = {{(TAG_WIDTH - ID_WIDTH){1'b0}}, i_BID};
        end
    endgenerate

    cpl_byte_count_calc #(
        .BE_WIDTH  (BYTE_ENABLES_WIDTH),
        .LEN_WIDTH (LEN_FIELD_WIDTH),
        .BC_WIDTH  (BYTE_COUNT_WIDTH),
        .OFF_WIDTH (BE_OFF_W)
    ) u_byte_count (
        .first_be_i   (r_first_be),
        .last_be_i    (r_last_be),
        .length_i     (r_length),
        .mem_not_io_i (r_mem_not_io),
        .byte_count_o (r_byte_count),
        .be_off_o     (r_be_off)
    );

    hold_state_e                   state_q, state_d;
    rr_prio_e                      prio_q, prio_d;
    logic                          load_en;
    logic                          grant_r;
    logic                          grant_b;
    logic [REQUESTER_ID_WIDTH-1:0] req_id_q, req_id_d;
    logic [TAG_WIDTH-1:0]          tag_q, tag_d;
    logic [TC_WIDTH-1:0]           tc_q, tc_d;
    logic [LEN_FIELD_WIDTH-1:0]    len_q, len_d;
    logic [LOWER_ADDR_FIELD-1:0]   laddr_q, laddr_d;
    logic [BYTE_COUNT_WIDTH-1:0]   bc_q, bc_d;
    logic                          type_q, type_d;
    logic                          err_q, err_d;
`ifdef AXI_CPL_STATUS_EN
    logic [2:0]                    status_q, status_d;
`endif

    // Holding state, priority and completion fields; async reset drops the entry
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            state_q  <= ST_EMPTY;
            prio_q   <= READ_RESP;
            req_id_q <= '0;
            tag_q    <= '0;
            tc_q     <= '0;
            len_q    <= '0;
            laddr_q  <= '0;
            bc_q     <= '0;
            type_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef AXI_CPL_STATUS_EN
            status_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            req_id_q <= req_id_d;
            tag_q    <= tag_d;
            tc_q     <= tc_d;
            len_q    <= len_d;
            laddr_q  <= laddr_d;
            bc_q     <= bc_d;
            type_q   <= type_d;
            err_q    <= err_d;
`ifdef AXI_CPL_STATUS_EN
            status_q <= status_d;
`endif
        end
    end

    // Arbitration, pop generation and next-entry mapping
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        grant_r  = 1'b0;
        grant_b  = 1'b0;
        req_id_d = req_id_q;
        tag_d    = tag_q;
        tc_d     = tc_q;
        len_d    = len_q;
        laddr_d  = laddr_q;
        bc_d     = bc_q;
        type_d   = type_q;
        err_d    = err_q;
`ifdef AXI_CPL_STATUS_EN
        status_d = status_q;
`endif
        // Register can take a new entry when empty or being accepted this cycle
        load_en = (state_q == ST_EMPTY) || i_cpl_info_inc;

        if (load_en) begin
            if (i_RVALID_fifo && i_BVALID_fifo) begin
                // Tie: serve the priority channel, then hand priority over
                grant_r = (prio_q == READ_RESP);
                grant_b = (prio_q == WRITE_RESP);
                prio_d  = (prio_q == READ_RESP) ? WRITE_RESP : READ_RESP;
            end else begin
                grant_r = i_RVALID_fifo;
                grant_b = i_BVALID_fifo;
            end
            state_d = (i_RVALID_fifo || i_BVALID_fifo) ? ST_FULL : ST_EMPTY;
        end

        if (grant_r) begin
            req_id_d = r_req_id;
            tag_d    = r_tag;
            tc_d     = r_tc;
            len_d    = r_length;
            laddr_d  = (r_mem_not_io == MEMORY) ? {r_addr_lsbs, r_be_off} : '0;
            bc_d     = r_byte_count;
            type_d   = (r_mem_not_io == MEMORY) ? DATA : NODATA;
            err_d    = resp_is_error(i_RRESP);
`ifdef AXI_CPL_STATUS_EN
            status_d = resp_to_status(i_RRESP);
`endif
        end else if (grant_b) begin
            req_id_d = b_req_id;
            tag_d    = b_tag;
            tc_d     = b_tc;
            len_d    = LEN_FIELD_WIDTH'(1);
            laddr_d  = '0;
            bc_d     = BYTE_COUNT_WIDTH'(BYTE_ENABLES_WIDTH);
            type_d   = NODATA;
            err_d    = resp_is_error(i_BRESP);
`ifdef AXI_CPL_STATUS_EN
            status_d = resp_to_status(i_BRESP);
`endif
        end
    end

    assign o_r_ch_read_info_inc     = grant_r;
    assign o_b_ch_read_inc          = grant_b;
    assign o_cpl_valid              = (state_q == ST_FULL);
    assign o_requester_id           = req_id_q;
    assign o_cpl_tag                = tag_q;
    assign o_cpl_traffic_class      = tc_q;
    assign o_cpl_length             = len_q;
    assign o_cpl_lower_address      = laddr_q;
    assign o_cpl_initial_byte_count = bc_q;
    assign o_cpl_type               = type_q;
    assign o_cpl_error_flag         = err_q;
`ifdef AXI_CPL_STATUS_EN
    assign o_cpl_status             = status_q;
`endif

endmodule

// File: tb/tb_axi_cpl_info_arbiter.sv
// Directed self-checking bench for axi_cpl_info_arbiter (default parameters).
// Build with AXI_CPL_STATUS_EN defined to also cover o_cpl_status.
module tb_axi_cpl_info_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  bid, rid;
    logic [1:0]  bresp, rresp;
    logic [18:0] buser;
    logic [42:0] ruser;
    logic        bvalid, rvalid, inc;
    logic        b_pop, r_pop;
    logic [15:0] req_id;
    logic [9:0]  tag;
    logic [2:0]  tc;
    logic [9:0]  len;
    logic [6:0]  laddr;
    logic [11:0] bc;
    logic        ctype, err, cvalid;
`ifdef AXI_CPL_STATUS_EN
    logic [2:0]  status;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi_cpl_info_arbiter dut (
        .i_clk                    (clk),
        .i_n_rst                  (rst_n),
        .i_BID                    (bid),
        .i_BRESP                  (bresp),
        .i_BUSER                  (buser),
        .i_BVALID_fifo            (bvalid),
        .o_b_ch_read_inc          (b_pop),
        .i_RID                    (rid),
        .i_RRESP                  (rresp),
        .i_RUSER                  (ruser),
        .i_RVALID_fifo            (rvalid),
        .o_r_ch_read_info_inc     (r_pop),
        .i_cpl_info_inc           (inc),
        .o_requester_id           (req_id),
        .o_cpl_tag                (tag),
        .o_cpl_traffic_class      (tc),
        .o_cpl_length             (len),
        .o_cpl_lower_address      (laddr),
        .o_cpl_initial_byte_count (bc),
        .o_cpl_type               (ctype),
        .o_cpl_error_flag         (err),
`ifdef AXI_CPL_STATUS_EN
        .o_cpl_status             (status),
`endif
        .o_cpl_valid              (cvalid)
    );

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [42:0] mk_ruser(input logic [15:0] rq, input logic [3:0] fbe,
                                             input logic [3:0] lbe, input logic [4:0] a,
                                             input logic [2:0] t, input logic [9:0] l,
                                             input logic m);
        return {rq, fbe, lbe, a, t, l, m};
    endfunction

    // Present one R-info entry to an empty arbiter; expect a single pop then a held entry
    task automatic push_r(input logic [9:0] id, input logic [42:0] u, input logic [1:0] resp);
        @(negedge clk);
        rid = id; ruser = u; rresp = resp; rvalid = 1'b1; inc = 1'b0;
        #1;
        check_val("r_pop", 32'(r_pop), 32'd1);
        check_val("b_pop_idle", 32'(b_pop), 32'd0);
        @(posedge clk); #1;
        check_val("r_pop_when_full", 32'(r_pop), 32'd0);
        check_val("valid_r", 32'(cvalid), 32'd1);
    endtask

    task automatic push_b(input logic [9:0] id, input logic [18:0] u, input logic [1:0] resp);
        @(negedge clk);
        bid = id; buser = u; bresp = resp; bvalid = 1'b1; inc = 1'b0;
        #1;
        check_val("b_pop", 32'(b_pop), 32'd1);
        check_val("r_pop_idle", 32'(r_pop), 32'd0);
        @(posedge clk); #1;
        check_val("b_pop_when_full", 32'(b_pop), 32'd0);
        check_val("valid_b", 32'(cvalid), 32'd1);
    endtask

    task automatic expect_entry(input string name, input logic [9:0] e_tag, input logic e_type,
                                input logic [9:0] e_len, input logic [6:0] e_la,
                                input logic [11:0] e_bc, input logic e_err);
        $display("txn %s tag=0x%0h type=%0d len=%0d laddr=0x%0h bc=%0d err=%0d",
                 name, tag, ctype, len, laddr, bc, err);
        check_val({name, "_tag"},   32'(tag),   32'(e_tag));
        check_val({name, "_type"},  32'(ctype), 32'(e_type));
        check_val({name, "_len"},   32'(len),   32'(e_len));
        check_val({name, "_laddr"}, 32'(laddr), 32'(e_la));
        check_val({name, "_bc"},    32'(bc),    32'(e_bc));
        check_val({name, "_err"},   32'(err),   32'(e_err));
    endtask

    // Accept the held entry with nothing pending: no pop, register empties
    task automatic drain();
        @(negedge clk);
        rvalid = 1'b0; bvalid = 1'b0; inc = 1'b1;
        #1;
        check_val("drain_no_r_pop", 32'(r_pop), 32'd0);
        check_val("drain_no_b_pop", 32'(b_pop), 32'd0);
        @(posedge clk); #1;
        check_val("drain_valid", 32'(cvalid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bid = '0; rid = '0; bresp = '0; rresp = '0; buser = '0; ruser = '0;
        bvalid = 1'b0; rvalid = 1'b0; inc = 1'b0;
        #12;
        check_val("rst_valid", 32'(cvalid), 32'd0);
        check_val("rst_tag", 32'(tag), 32'd0);
        check_val("rst_bc", 32'(bc), 32'd0);
        check_val("rst_req_id", 32'(req_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain 4-DW memory read
        push_r(10'd5, mk_ruser(16'hABCD, 4'hF, 4'hF, 5'h00, 3'd2, 10'd4, 1'b1), 2'b00);
        expect_entry("t1", 10'd5, 1'b1, 10'd4, 7'h00, 12'd16, 1'b0);
        check_val("t1_req_id", 32'(req_id), 32'h0000ABCD);
        check_val("t1_tc", 32'(tc), 32'd2);
        drain();

        // Write response with DECERR
        push_b(10'd7, {16'h1234, 3'd3}, 2'b11);
        expect_entry("t3", 10'd7, 1'b0, 10'd1, 7'h00, 12'd4, 1'b1);
        check_val("t3_req_id", 32'(req_id), 32'h00001234);
        check_val("t3_tc", 32'(tc), 32'd3);
`ifdef AXI_CPL_STATUS_EN
        check_val("t3_status", 32'(status), 32'd1);
`endif
        drain();

        // Single DW, first_be=0110, SLVERR
        push_r(10'd9, mk_ruser(16'h0001, 4'b0110, 4'b0000, 5'h03, 3'd0, 10'd1, 1'b1), 2'b10);
        expect_entry("t4", 10'd9, 1'b1, 10'd1, 7'h0D, 12'd2, 1'b1);
`ifdef AXI_CPL_STATUS_EN
        check_val("t4_status", 32'(status), 32'd4);
`endif
        drain();

        // 1024 DW full read wraps to 0
        push_r(10'h3FF, mk_ruser(16'h0000, 4'hF, 4'hF, 5'h00, 3'd0, 10'd0, 1'b1), 2'b00);
        expect_entry("t5a", 10'h3FF, 1'b1, 10'd0, 7'h00, 12'd0, 1'b0);
        drain();

        // 3 DW with partial edge DWs, EXOKAY is success
        push_r(10'd3, mk_ruser(16'h0000, 4'b1000, 4'b0001, 5'h1F, 3'd0, 10'd3, 1'b1), 2'b01);
        expect_entry("t5b", 10'd3, 1'b1, 10'd3, 7'h7F, 12'd6, 1'b0);
`ifdef AXI_CPL_STATUS_EN
        check_val("t5b_status", 32'(status), 32'd0);
`endif
        drain();

        // IO read: no data-address offset, byte count 4, Cpl type
        push_r(10'd4, mk_ruser(16'hBEEF, 4'b0011, 4'b0000, 5'h0A, 3'd1, 10'd1, 1'b0), 2'b00);
        expect_entry("io", 10'd4, 1'b0, 10'd1, 7'h00, 12'd4, 1'b0);
        drain();

        // Single DW with empty first_be: byte count 1
        push_r(10'd6, mk_ruser(16'h0000, 4'b0000, 4'b0000, 5'h02, 3'd0, 10'd1, 1'b1), 2'b00);
        expect_entry("zbe", 10'd6, 1'b1, 10'd1, 7'h08, 12'd1, 1'b0);
        drain();

        // Both FIFOs valid, continuous accept: R,B,R,B at one per cycle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                rid = 10'd1; ruser = mk_ruser(16'h0000, 4'hF, 4'h0, 5'h00, 3'd0, 10'd1, 1'b0);
                rresp = 2'b00; rvalid = 1'b1;
                bid = 10'd2; buser = '0; bresp = 2'b00; bvalid = 1'b1;
                inc = 1'b1;
            end
            #1;
            check_val("rr_r_pop", 32'(r_pop), 32'((i % 2) == 0));
            check_val("rr_b_pop", 32'(b_pop), 32'((i % 2) == 1));
            @(posedge clk); #1;
            $display("txn rr%0d tag=0x%0h valid=%0d", i, tag, cvalid);
            check_val("rr_valid", 32'(cvalid), 32'd1);
            check_val("rr_tag", 32'(tag), ((i % 2) == 0) ? 32'd1 : 32'd2);
        end

        // Held entry with no accept for 5 cycles: no pops, fields stable
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            inc = 1'b0;
            #1;
            check_val("hold_r_pop", 32'(r_pop), 32'd0);
            check_val("hold_b_pop", 32'(b_pop), 32'd0);
            @(posedge clk); #1;
            check_val("hold_valid", 32'(cvalid), 32'd1);
            check_val("hold_tag", 32'(tag), 32'd2);
        end

        // Asynchronous reset mid-cycle discards the entry
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_valid", 32'(cvalid), 32'd0);
        check_val("async_rst_tag", 32'(tag), 32'd0);

        // After reset priority is READ again
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("post_rst_r_pop", 32'(r_pop), 32'd1);
        check_val("post_rst_b_pop", 32'(b_pop), 32'd0);
        @(posedge clk); #1;
        check_val("post_rst_tag", 32'(tag), 32'd1);
        drain();

        // Lone R request must not move priority (still WRITE after the tie above)
        push_r(10'd8, mk_ruser(16'h0000, 4'hF, 4'h0, 5'h00, 3'd0, 10'd1, 1'b0), 2'b00);
        check_val("lone_r_tag", 32'(tag), 32'd8);
        drain();
        @(negedge clk);
        rid = 10'd1; rvalid = 1'b1; bid = 10'd2; bvalid = 1'b1; inc = 1'b0;
        #1;
        check_val("prio_keep_b_pop", 32'(b_pop), 32'd1);
        check_val("prio_keep_r_pop", 32'(r_pop), 32'd0);
        @(posedge clk); #1;
        check_val("prio_keep_tag", 32'(tag), 32'd2);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
